// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the IF-stage fetch and the
//   MEM-stage data access. One transaction is in flight at a time. When both
//   stages request, the data side wins, but a fetch that has been passed over
//   MAX_DM_STREAK times in a row wins the next arbitration.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   if_req_i/if_addr_i           fetch request (held until if_ack_o)
//   if_ack_o/if_rdata_o          one-cycle fetch completion + instruction
//   dm_req_i/dm_we_i/dm_addr_i/
//   dm_wdata_i                   data request (held until dm_ack_o)
//   dm_ack_o/dm_rdata_o          one-cycle data completion + read data
//   mem_req_o/mem_we_o/
//   mem_addr_o/mem_wdata_o       memory request, held until mem_ack_i
//   mem_ack_i/mem_rdata_i        memory completion, rdata valid same cycle
//   stall_o                      pipeline stall while any stage waits
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       grant_if, grant_dm, mem_done;

  // next-state, arbitration and starvation counter
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      IDLE: begin
        // data wins a tie unless the fetch has been starved long enough
        if (dm_req_i && !(if_req_i && streak_q == STREAK_MAX)) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
          if (!if_req_i)                streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
        end else if (if_req_i) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
          streak_d = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack_i) begin
          mem_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // registered memory-side and requester-side outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      if (grant_dm) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= dm_we_i;
        mem_addr_o  <= dm_addr_i;
        mem_wdata_o <= dm_wdata_i;
      end else if (grant_if) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
      end else if (mem_done) begin
        mem_req_o   <= 1'b0;
      end
      // acks are single-cycle: they fall again on the RESP -> IDLE edge
      if_ack_o <= mem_done && (state_q == BUSY_IF);
      dm_ack_o <= mem_done && (state_q == BUSY_DM);
      if (mem_done && state_q == BUSY_IF) if_rdata_o <= mem_rdata_i;
      // write acks capture too; the value is meaningless for writes
      if (mem_done && state_q == BUSY_DM) dm_rdata_o <= mem_rdata_i;
    end
  end

  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios with literal expectations, then a randomized phase.
//   A transaction-level model of the arbiter is checked against the DUT on
//   every falling edge.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0;
  logic          dm_ack_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;

  // memory side: manual (mode 0), random wait (mode 1), zero wait (mode 2)
  int            mode = 0;
  logic          man_ack = 1'b0, auto_ack = 1'b0;
  logic [DW-1:0] man_rdata = '0, auto_rdata = '0;
  assign mem_ack_i   = (mode == 0) ? man_ack   : auto_ack;
  assign mem_rdata_i = (mode == 0) ? man_rdata : auto_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  bit            m_valid = 0;
  bit            m_busy, m_dm, m_resp, m_if_ack, m_dm_ack;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  int            m_streak;

  always @(posedge clk) begin
    if (rst_i) begin
      m_valid = 1; m_busy = 0; m_dm = 0; m_resp = 0;
      m_if_ack = 0; m_dm_ack = 0; m_req = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
      m_streak = 0;
    end else if (m_resp) begin
      m_resp = 0; m_if_ack = 0; m_dm_ack = 0;
    end else if (m_busy) begin
      if (mem_ack_i) begin
        m_busy = 0; m_resp = 1; m_req = 0;
        if (m_dm) begin m_dm_ack = 1; m_dm_rdata = mem_rdata_i; end
        else      begin m_if_ack = 1; m_if_rdata = mem_rdata_i; end
      end
    end else if (dm_req_i && !(if_req_i && m_streak >= MAXS)) begin
      m_busy = 1; m_dm = 1; m_req = 1;
      m_we = dm_we_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
      m_streak = if_req_i ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
    end else if (if_req_i) begin
      m_busy = 1; m_dm = 0; m_req = 1;
      m_we = 0; m_addr = if_addr_i; m_wdata = '0;
      m_streak = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mem_req", mem_req_o, m_req);
      chk("if_ack", if_ack_o, m_if_ack);
      chk("dm_ack", dm_ack_o, m_dm_ack);
      chk("if_rdata", if_rdata_o, m_if_rdata);
      chk("dm_rdata", dm_rdata_o, m_dm_rdata);
      chk("stall", stall_o, (if_req_i & ~m_if_ack) | (dm_req_i & ~m_dm_ack));
      if (m_req) begin
        chk("mem_we", mem_we_o, m_we);
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_wdata", mem_wdata_o, m_wdata);
      end
    end
  end

  // ---------------- memory responder ----------------
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  bit in_txn = 0;
  int wait_cnt = 0;

  always @(posedge clk) begin
    #1;
    auto_ack = 1'b0;
    if (mode == 2) begin
      auto_ack = mem_req_o;
    end else if (mode == 1) begin
      if (mem_req_o) begin
        if (!in_txn) begin in_txn = 1; wait_cnt = $urandom_range(0, 3); end
        if (wait_cnt == 0) begin auto_ack = 1'b1; in_txn = 0; end
        else wait_cnt--;
      end else begin
        auto_ack = ($urandom_range(0, 9) == 0);  // stray ack, must be ignored
      end
    end
    if (auto_ack && mem_req_o) begin
      if (mem_we_o) begin
        mem_arr[mem_addr_o] = mem_wdata_o;
        auto_rdata = $urandom;
      end else begin
        auto_rdata = mem_arr.exists(mem_addr_o) ? mem_arr[mem_addr_o]
                                                : (mem_addr_o ^ 32'hA5A5_0000);
      end
    end else begin
      auto_rdata = $urandom;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    string order;
    int    dm_acks, ca, cr, cyc;
    bit    seen_if, prev_req, found;

    // reset and idle
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_mem_req", mem_req_o, 1'b0);
      chk("idle_stall", stall_o, 1'b0);
    end

    // single fetch, memory acks in cycle 3
    if_req_i = 1'b1; if_addr_i = 32'h40;
    #1 chk("fetch_stall_c0", stall_o, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 3) begin
        chk("fetch_mem_req", mem_req_o, 1'b1);
        chk("fetch_mem_addr", mem_addr_o, 32'h40);
        chk("fetch_mem_we", mem_we_o, 1'b0);
        chk("fetch_stall", stall_o, 1'b1);
        chk("fetch_no_ack", if_ack_o, 1'b0);
      end
      if (c == 3) begin man_ack = 1'b1; man_rdata = 32'h2008_0005; end
      if (c == 4) begin
        man_ack = 1'b0;
        chk("fetch_ack", if_ack_o, 1'b1);
        chk("fetch_rdata", if_rdata_o, 32'h2008_0005);
        chk("model_if_rdata", m_if_rdata, 32'h2008_0005);
        chk("fetch_stall_c4", stall_o, 1'b0);
        if_req_i = 1'b0;
      end
      if (c == 5) chk("fetch_ack_gone", if_ack_o, 1'b0);
    end

    // data write, zero-wait memory
    mode = 2;
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'hDEAD_BEEF;
    tick();
    chk("wr_mem_req", mem_req_o, 1'b1);
    chk("wr_mem_we", mem_we_o, 1'b1);
    chk("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("wr_mem_addr", mem_addr_o, 32'h100);
    tick();
    chk("wr_dm_ack", dm_ack_o, 1'b1);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    tick();
    chk("wr_dm_ack_gone", dm_ack_o, 1'b0);
    tick();

    // both requesting: starvation limit forces the fetch in
    if_addr_i = 32'h1000; dm_addr_i = 32'h2000;
    if_req_i = 1'b1; dm_req_i = 1'b1;
    order = ""; dm_acks = 0; seen_if = 0; prev_req = 0;
    for (int i = 0; i < 80 && order.len() < 6; i++) begin
      tick();
      if (mem_req_o && !prev_req) order = {order, (mem_addr_o == 32'h2000) ? "D" : "I"};
      prev_req = mem_req_o;
      if (if_ack_o) seen_if = 1;
      if (dm_ack_o && !seen_if) dm_acks++;
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    total++;
    if (order != "DDDDID") begin
      bad++;
      $display("FAIL grant_order got=%s want=DDDDID", order);
    end
    chk("dm_acks_before_if", dm_acks, 4);
    for (int i = 0; i < 5; i++) tick();

    // stray memory ack while idle
    mode = 0;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_mem_req", mem_req_o, 1'b0);
      chk("stray_if_ack", if_ack_o, 1'b0);
      chk("stray_dm_ack", dm_ack_o, 1'b0);
    end

    // reset while BUSY_DM, then a late memory ack
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
    tick();
    chk("mid_busy", mem_req_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; dm_req_i = 1'b0;
    chk("mid_rst_mem_req", mem_req_o, 1'b0);
    man_ack = 1'b1; man_rdata = 32'h1234_5678;
    tick();
    man_ack = 1'b0;
    chk("mid_no_ack", dm_ack_o, 1'b0);
    chk("mid_idle", mem_req_o, 1'b0);
    tick();
    chk("mid_no_ack2", dm_ack_o, 1'b0);
    chk("mid_rdata", dm_rdata_o, 32'h0);

    // back-to-back fetch
    mode = 2;
    if_req_i = 1'b1; if_addr_i = 32'h80;
    ca = -1; cr = -1; found = 0; prev_req = mem_req_o;
    for (cyc = 0; cyc < 30 && !found; cyc++) begin
      tick();
      if (if_ack_o && ca < 0) ca = cyc;
      if (ca >= 0 && mem_req_o && !prev_req) begin cr = cyc; found = 1; end
      prev_req = mem_req_o;
    end
    if_req_i = 1'b0;
    chk("b2b_found", found, 1'b1);
    chk("b2b_gap", cr - ca, 2);
    for (int i = 0; i < 5; i++) tick();

    // randomized traffic
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (if_req_i) begin
        if (if_ack_o) begin
          if ($urandom_range(0, 3) == 0) if_addr_i = AW'({$urandom_range(0, 15), 2'b00});
          else if_req_i = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req_i = 1'b1;
        if_addr_i = AW'({$urandom_range(0, 15), 2'b00});
      end
      if (dm_req_i) begin
        if (dm_ack_o) begin
          if ($urandom_range(0, 3) == 0) begin
            dm_we_i = $urandom_range(0, 1) == 1;
            dm_addr_i = AW'({$urandom_range(0, 15), 2'b00});
            dm_wdata_i = $urandom;
          end else dm_req_i = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        dm_req_i = 1'b1;
        dm_we_i = $urandom_range(0, 1) == 1;
        dm_addr_i = AW'({$urandom_range(0, 15), 2'b00});
        dm_wdata_i = $urandom;
      end
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage data access in the 5-stage MIPS pipeline.
- Sequences each transaction over a request/ack handshake and picks a winner when both stages request.
- Drives a pipeline stall while either stage is waiting.
- Sits between the IF/MEM stage logic and the memory model; the hazard/flush logic consumes stall_o.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch waits before the fetch is forced to win (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
if_req_i  in  1  fetch request; held with if_addr_i stable until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_ack_o  out  1  one-cycle fetch completion pulse
if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o=1
dm_req_i  in  1  data request; held with addr/we/wdata stable until dm_ack_o
dm_we_i  in  1  1=write, 0=read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_ack_o  out  1  one-cycle data completion pulse
dm_rdata_o  out  DATA_W  read data, valid while dm_ack_o=1
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion; rdata valid same cycle
mem_rdata_i  in  DATA_W  memory read data
stall_o  out  1  pipeline stall

Behaviour:
- Single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - FSM=IDLE; streak=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - if_ack_o=0, dm_ack_o=0, if_rdata_o=0, dm_rdata_o=0.
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE, neither request: stay in IDLE.
- IDLE, arbitration:
  - Only dm_req_i=1 → BUSY_DM.
  - Only if_req_i=1 → BUSY_IF.
  - Both requesting: DM wins unless streak==MAX_DM_STREAK, in which case IF wins.
- Entering a BUSY state registers mem_req_o=1 plus addr/we/wdata from the winner.
  - For IF the registered values are we=0 and wdata=0.
- BUSY_x:
  - mem_* outputs are held constant until mem_ack_i=1 is sampled.
  - On that edge: mem_req_o←0, the matching ack_o←1, rdata_o←mem_rdata_i, next state RESP.
- RESP: lasts exactly 1 cycle (ack high), then IDLE, with ack_o cleared.
- Requester request lines:
  - A request still high in the IDLE after RESP is treated as a new request.
  - Requesters must drop req on the cycle ack_o is seen unless issuing back-to-back.
- rdata_o holds its last captured value outside ack.
  - dm_rdata_o is also captured on write acks (value undefined for writes).
- Latency: request sampled in IDLE at cycle N → mem_req_o high at N+1.
  - mem_ack_i at cycle M → ack_o high at M+1 → IDLE at M+2.
  - With a zero-wait memory (mem_ack_i high at N+1), ack_o is high at N+2.
- Starvation counter (streak):
  - On a DM grant with if_req_i=1: increment, saturating at MAX_DM_STREAK.
  - On an IF grant: clear.
  - On a DM grant with if_req_i=0: clear.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- mem_ack_i sampled in IDLE or RESP is ignored (no state change, no ack_o).
- Reset asserted mid-transaction:
  - Everything returns to reset values on that edge.
  - The outstanding memory response is discarded by the IDLE rule above.
- A request dropped while its transaction is in BUSY is not aborted; the transaction completes and ack_o still pulses.

Test Plan:
- Reset and idle: assert rst_i 2 cycles, then no requests for 10 cycles → all outputs 0, stall_o=0, mem_req_o never rises.
- Single fetch:
  - Stimulus: if_req_i=1 with if_addr_i=0x0000_0040 at cycle 0; memory acks at cycle 3 with mem_rdata_i=0x2008_0005.
  - Response: mem_req_o=1 and mem_addr_o=0x40 on cycles 1-3 with mem_we_o=0; if_ack_o=1 and if_rdata_o=0x2008_0005 on cycle 4 only; stall_o=1 on cycles 0-3.
- Data write:
  - Stimulus: dm_req_i=1, dm_we_i=1, dm_addr_i=0x100, dm_wdata_i=0xDEAD_BEEF; zero-wait memory.
  - Response: mem_we_o=1, mem_wdata_o=0xDEAD_BEEF on cycle 1; dm_ack_o pulses on cycle 2.
- Simultaneous requests, MAX_DM_STREAK=4, zero-wait memory:
  - Stimulus: if_req_i held high; dm_req_i re-raised after every ack.
  - Response: grant order is DM,DM,DM,DM,IF,DM...; if_ack_o first pulses after the 4th dm_ack_o.
- Reset mid-op:
  - Stimulus: pulse rst_i while in BUSY_DM, then assert mem_ack_i 1 cycle later.
  - Response: mem_req_o=0 the cycle after reset; no dm_ack_o; FSM stays in IDLE.
- Stray mem_ack_i while idle: no ack_o, no state change.
- Back-to-back fetch: if_req_i held high through ack → second transaction starts; mem_req_o rises 2 cycles after the first if_ack_o.
